// File: rtl/addsub_norm_stage.sv
// Add/sub normalization stage: registers the aligned-operand sum, effective carry and
// exponent, then counts leading zeros of the mantissa field in a second slot.
module addsub_norm_stage #(
  parameter int FractionSize = 23,
  parameter int ExponentSize = 8,
  parameter int GuardBits    = 3,
  localparam int MantissaSize = FractionSize + 1,
  localparam int RoundingSize = MantissaSize + GuardBits,
  localparam int ShiftSize    = $clog2(MantissaSize + 1)
) (
  input  logic                    Clk,
  input  logic                    RstN,
  input  logic                    Flush,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [RoundingSize-1:0] Adder1,
  input  logic [RoundingSize-1:0] Adder2,
  input  logic                    EffOperation,
  input  logic                    OpSel,
  input  logic [ExponentSize-1:0] MDFinalExponent,
  input  logic [ExponentSize-1:0] ExponentBase,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [RoundingSize-1:0] AdderResult,
  output logic                    EffCarry,
  output logic [ShiftSize-1:0]    NormShifts,
  output logic [ExponentSize-1:0] ResultExponent,
  output logic                    ZeroResult
);

  logic [RoundingSize:0]   full_sum;
  logic                    s1_valid;
  logic [RoundingSize-1:0] s1_sum;
  logic                    s1_eff_carry;
  logic                    s1_op_sel;
  logic [ExponentSize-1:0] s1_exp;
  logic                    s2_load;
  logic                    s1_load;

  // Priority form: the highest set bit is assigned last, so it wins.
  function automatic logic [ShiftSize-1:0] lzc(input logic [MantissaSize-1:0] field);
    logic [ShiftSize-1:0] count;
    count = ShiftSize'(MantissaSize);
    for (int i = 0; i < MantissaSize; i++) begin
      if (field[i]) count = ShiftSize'(MantissaSize - 1 - i);
    end
    return count;
  endfunction

  assign full_sum = {1'b0, Adder1} + {1'b0, Adder2};
  assign s2_load  = ~OutValid | OutReady;
  assign s1_load  = ~s1_valid | s2_load;
  assign InReady  = s1_load;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_eff_carry <= 1'b0;
      s1_op_sel    <= 1'b0;
      s1_exp       <= '0;
    end else begin
      if (Flush) s1_valid <= 1'b0;
      else if (s1_load) s1_valid <= InValid;
      if (s1_load && InValid) begin
        s1_sum       <= full_sum[RoundingSize-1:0];
        s1_eff_carry <= full_sum[RoundingSize] & ~EffOperation & ~OpSel;
        s1_op_sel    <= OpSel;
        s1_exp       <= OpSel ? MDFinalExponent : ExponentBase;
      end
    end
  end

  // Output data only changes when a valid S1 entry moves in, so stalled results hold.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      OutValid       <= 1'b0;
      AdderResult    <= '0;
      EffCarry       <= 1'b0;
      NormShifts     <= '0;
      ResultExponent <= '0;
      ZeroResult     <= 1'b0;
    end else begin
      if (Flush) OutValid <= 1'b0;
      else if (s2_load) OutValid <= s1_valid;
      if (s2_load && s1_valid) begin
        AdderResult    <= s1_sum;
        EffCarry       <= s1_eff_carry;
        NormShifts     <= lzc(s1_sum[RoundingSize-1:GuardBits]);
        ResultExponent <= s1_exp;
        ZeroResult     <= ~|s1_sum & ~s1_eff_carry & ~s1_op_sel;
      end
    end
  end

endmodule

// File: tb/tb_addsub_norm_stage.sv
// Directed-vector bench for addsub_norm_stage: default-width table through a scoreboard,
// backpressure/flush/reset sequences, and a wide instance against a behavioural model.
module tb_addsub_norm_stage;

  localparam logic [7:0] MdExp   = 8'h81;
  localparam logic [7:0] BaseExp = 8'h7F;

  typedef struct packed {
    logic [26:0] sum;
    logic        carry;
    logic [4:0]  nsh;
    logic [7:0]  exp;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [26:0] a1;
    logic [26:0] a2;
    logic        eo;
    logic        os;
    res_t        res;
  } vec_t;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [26:0] Adder1, Adder2;
  logic        EffOperation, OpSel;
  logic [7:0]  MDFinalExponent, ExponentBase;
  logic        OutValid, OutReady;
  logic [26:0] AdderResult;
  logic        EffCarry;
  logic [4:0]  NormShifts;
  logic [7:0]  ResultExponent;
  logic        ZeroResult;

  logic        w_flush, w_in_valid, w_in_ready, w_eff_op, w_op_sel, w_out_valid, w_out_ready;
  logic [55:0] w_a1, w_a2, w_res;
  logic [10:0] w_md, w_base, w_exp;
  logic        w_eff_carry, w_zero;
  logic [5:0]  w_nsh;

  int   checks = 0;
  int   failures = 0;
  res_t cur_exp;
  res_t q[$];
  int   occ;
  logic stall_prev;
  res_t held;
  logic bp_mode = 1'b0;
  logic ready_val = 1'b1;
  int   total_waits;
  vec_t vecs[12];

  always #5 Clk = ~Clk;

  addsub_norm_stage dut (
    .Clk(Clk), .RstN(RstN), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Adder1(Adder1), .Adder2(Adder2), .EffOperation(EffOperation), .OpSel(OpSel),
    .MDFinalExponent(MDFinalExponent), .ExponentBase(ExponentBase),
    .OutValid(OutValid), .OutReady(OutReady), .AdderResult(AdderResult),
    .EffCarry(EffCarry), .NormShifts(NormShifts), .ResultExponent(ResultExponent),
    .ZeroResult(ZeroResult)
  );

  addsub_norm_stage #(.FractionSize(52), .ExponentSize(11), .GuardBits(3)) u_wide (
    .Clk(Clk), .RstN(RstN), .Flush(w_flush), .InValid(w_in_valid), .InReady(w_in_ready),
    .Adder1(w_a1), .Adder2(w_a2), .EffOperation(w_eff_op), .OpSel(w_op_sel),
    .MDFinalExponent(w_md), .ExponentBase(w_base),
    .OutValid(w_out_valid), .OutReady(w_out_ready), .AdderResult(w_res),
    .EffCarry(w_eff_carry), .NormShifts(w_nsh), .ResultExponent(w_exp),
    .ZeroResult(w_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [26:0] a1, a2, input logic eo, os,
                               input logic [26:0] sum, input logic c,
                               input logic [4:0] n, input logic z);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.eo = eo; v.os = os;
    v.res.sum = sum; v.res.carry = c; v.res.nsh = n; v.res.zero = z;
    v.res.exp = os ? MdExp : BaseExp;
    return v;
  endfunction

  // Bit-scan reference for the wide instance.
  task automatic wide_model(input logic [55:0] a1, a2, input logic eo, os,
                            input logic [10:0] md, base,
                            output logic [55:0] s, output logic c, output logic [5:0] n,
                            output logic [10:0] e, output logic z);
    logic [56:0] f;
    logic        found;
    f = {1'b0, a1} + {1'b0, a2};
    s = f[55:0];
    c = f[56] & ~eo & ~os;
    n = 0;
    found = 1'b0;
    for (int i = 55; i >= 3; i--) begin
      if (!found) begin
        if (s[i]) found = 1'b1;
        else n = n + 6'd1;
      end
    end
    e = os ? md : base;
    z = (s == 56'd0) & ~c & ~os;
  endtask

  always @(posedge Clk) begin
    #1;
    OutReady = bp_mode ? ($time % 30 < 10) : ready_val;
  end

  // Scoreboard: expected results are queued on accept and popped on handshake.
  always @(negedge Clk) begin
    if (!RstN) begin
      q.delete();
      occ = 0;
      stall_prev = 1'b0;
    end else begin
      if (OutReady === 1'b0 || OutReady === 1'b1)
        check("in_ready", 64'(InReady), 64'(!(occ == 2 && !OutReady)));
      if (stall_prev) begin
        check("stall_sum", 64'(AdderResult), 64'(held.sum));
        check("stall_nsh", 64'(NormShifts), 64'(held.nsh));
        check("stall_exp", 64'(ResultExponent), 64'(held.exp));
        check("stall_valid", 64'(OutValid), 64'd1);
      end
      if (OutValid && OutReady) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          res_t r;
          r = q.pop_front();
          check("sum", 64'(AdderResult), 64'(r.sum));
          check("eff_carry", 64'(EffCarry), 64'(r.carry));
          check("norm_shifts", 64'(NormShifts), 64'(r.nsh));
          check("exponent", 64'(ResultExponent), 64'(r.exp));
          check("zero", 64'(ZeroResult), 64'(r.zero));
        end
      end
      stall_prev = OutValid && !OutReady && !Flush;
      held = '{AdderResult, EffCarry, NormShifts, ResultExponent, ZeroResult};
      if (Flush) begin
        q.delete();
        occ = 0;
      end else begin
        occ = occ + int'(InValid && InReady) - int'(OutValid && OutReady);
        if (InValid && InReady) q.push_back(cur_exp);
      end
    end
  end

  task automatic drive(input vec_t v);
    Adder1 = v.a1; Adder2 = v.a2; EffOperation = v.eo; OpSel = v.os;
    cur_exp = v.res;
    InValid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    logic acc;
    acc = 1'b0;
    drive(v);
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      #1;
      if (acc) break;
      total_waits++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wide_case(input logic [55:0] a1, a2, input logic eo, os);
    logic [55:0] s;
    logic        c, z, seen;
    logic [5:0]  n;
    logic [10:0] e;
    w_a1 = a1; w_a2 = a2; w_eff_op = eo; w_op_sel = os;
    w_md = 11'($urandom); w_base = 11'($urandom);
    wide_model(a1, a2, eo, os, w_md, w_base, s, c, n, e, z);
    w_in_valid = 1'b1;
    @(negedge Clk);
    check("w_in_ready", 64'(w_in_ready), 64'd1);
    @(posedge Clk);
    #1;
    w_in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (w_out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("w_out_valid", 64'(seen), 64'd1);
    check("w_sum", 64'(w_res), 64'(s));
    check("w_eff_carry", 64'(w_eff_carry), 64'(c));
    check("w_norm_shifts", 64'(w_nsh), 64'(n));
    check("w_exponent", 64'(w_exp), 64'(e));
    check("w_zero", 64'(w_zero), 64'(z));
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mkv(27'h4000000, 27'h4000000, 0, 0, 27'h0000000, 1, 5'd24, 0);
    vecs[1]  = mkv(27'h4000000, 27'h3C00000, 1, 0, 27'h7C00000, 0, 5'd0,  0);
    vecs[2]  = mkv(27'h4000000, 27'h4000000, 1, 0, 27'h0000000, 0, 5'd24, 1);
    vecs[3]  = mkv(27'h0000008, 27'h0000000, 0, 0, 27'h0000008, 0, 5'd23, 0);
    vecs[4]  = mkv(27'h0000008, 27'h0000000, 0, 1, 27'h0000008, 0, 5'd23, 0);
    vecs[5]  = mkv(27'h0000004, 27'h0000000, 0, 0, 27'h0000004, 0, 5'd24, 0);
    vecs[6]  = mkv(27'h7FFFFFF, 27'h0000001, 0, 0, 27'h0000000, 1, 5'd24, 0);
    vecs[7]  = mkv(27'h1234560, 27'h0000A00, 0, 0, 27'h1234F60, 0, 5'd2,  0);
    vecs[8]  = mkv(27'h4000000, 27'h4000000, 0, 1, 27'h0000000, 0, 5'd24, 0);
    vecs[9]  = mkv(27'h0000000, 27'h0000000, 0, 0, 27'h0000000, 0, 5'd24, 1);
    vecs[10] = mkv(27'h7FFFFF8, 27'h0000000, 1, 0, 27'h7FFFFF8, 0, 5'd0,  0);
    vecs[11] = mkv(27'h0400000, 27'h0300000, 0, 0, 27'h0700000, 0, 5'd4,  0);

    RstN = 1'b0; Flush = 1'b0; InValid = 1'b0;
    Adder1 = '0; Adder2 = '0; EffOperation = 1'b0; OpSel = 1'b0;
    MDFinalExponent = MdExp; ExponentBase = BaseExp;
    w_flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_a1 = '0; w_a2 = '0; w_eff_op = 1'b0; w_op_sel = 1'b0; w_md = '0; w_base = '0;
    total_waits = 0;
    cur_exp = '0;

    #2;
    check("rst_out_valid", 64'(OutValid), 64'd0);
    check("rst_in_ready", 64'(InReady), 64'd1);
    check("rst_outputs", 64'({AdderResult, EffCarry, NormShifts, ResultExponent, ZeroResult}), 64'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    RstN = 1'b1;

    // Back-to-back stream with no backpressure: one accept per cycle.
    foreach (vecs[i]) send(vecs[i]);
    idle(5);
    check("stream_throughput", 64'(total_waits), 64'd0);
    check("stream_drain", 64'(q.size()), 64'd0);

    // Two-cycle latency of a single operand.
    drive(vecs[3]);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    @(negedge Clk);
    check("latency_c1", 64'(OutValid), 64'd0);
    @(negedge Clk);
    check("latency_c2", 64'(OutValid), 64'd1);
    idle(3);

    // Backpressure: OutReady follows 1,0,0,1,0,0,...
    bp_mode = 1'b1;
    for (int i = 0; i < 6; i++) send(vecs[i]);
    idle(20);
    check("bp_drain", 64'(q.size()), 64'd0);
    bp_mode = 1'b0;

    // Flush with two operands in flight.
    ready_val = 1'b0;
    idle(1);
    send(vecs[7]);
    send(vecs[1]);
    InValid = 1'b0;
    Flush = 1'b1;
    @(negedge Clk);
    check("pre_flush_valid", 64'(OutValid), 64'd1);
    check("full_in_ready", 64'(InReady), 64'd0);
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    ready_val = 1'b1;
    @(negedge Clk);
    check("flush_out_valid", 64'(OutValid), 64'd0);
    idle(3);
    check("flush_no_output", 64'(OutValid), 64'd0);

    // Asynchronous reset mid-stream.
    send(vecs[0]);
    send(vecs[6]);
    InValid = 1'b0;
    #1;
    RstN = 1'b0;
    #1;
    check("arst_out_valid", 64'(OutValid), 64'd0);
    check("arst_in_ready", 64'(InReady), 64'd1);
    check("arst_outputs", 64'({AdderResult, EffCarry, NormShifts, ResultExponent, ZeroResult}), 64'd0);
    @(posedge Clk);
    #1;
    RstN = 1'b1;
    check("post_rst_valid", 64'(OutValid), 64'd0);
    drive(vecs[11]);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    @(negedge Clk);
    check("rst_latency_c1", 64'(OutValid), 64'd0);
    @(negedge Clk);
    check("rst_latency_c2", 64'(OutValid), 64'd1);
    idle(3);
    check("rst_drain", 64'(q.size()), 64'd0);

    // Wide configuration against the reference model.
    wide_case(56'd0, 56'd0, 1'b0, 1'b0);
    wide_case(56'd5, 56'd0, 1'b0, 1'b0);
    wide_case(56'd8, 56'd0, 1'b1, 1'b0);
    wide_case(56'hFF_FFFF_FFFF_FFFF, 56'd1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [55:0] r1, r2;
      r1 = 56'({$urandom, $urandom}) >> $urandom_range(0, 56);
      r2 = $urandom_range(0, 1) ? 56'({$urandom, $urandom}) : 56'd0;
      wide_case(r1, r2, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
